// File: rtl/weight_fetch_sequencer.sv
// Walks every (kernel, pixel) weight address, reads each byte from the weight SRAM
// and hands it to the kernel weight buffer over a valid/ready handshake.
module weight_fetch_sequencer #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned KERN_AW  = 4,
  parameter int unsigned PIX_AW   = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [KERN_AW-1:0] numKern,
  input  logic [PIX_AW-1:0]  numPix,
  input  logic [7:0]         weightIn,
  output logic               enableWSRAM,
  output logic               writeWSRAM,
  output logic               readWSRAM,
  output logic [KERN_AW-1:0] WkernAddr,
  output logic [PIX_AW-1:0]  WpixAddr,
  output logic [7:0]         weightOut,
  output logic [KERN_AW-1:0] weightKern,
  output logic [PIX_AW-1:0]  weightPix,
  output logic               weightValid,
  input  logic               weightReady,
  output logic               busy,
  output logic               weightsPulled
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  state_t             state_q, state_d;
  logic [KERN_AW-1:0] kern_q, kern_d;
  logic [PIX_AW-1:0]  pix_q, pix_d;
  logic [KERN_AW-1:0] nk_q, nk_d;
  logic [PIX_AW-1:0]  np_q, np_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [7:0]         wout_q, wout_d;
  logic [KERN_AW-1:0] wkern_q, wkern_d;
  logic [PIX_AW-1:0]  wpix_q, wpix_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kern_q  <= '0;
      pix_q   <= '0;
      nk_q    <= '0;
      np_q    <= '0;
      wcnt_q  <= '0;
      wout_q  <= '0;
      wkern_q <= '0;
      wpix_q  <= '0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      pix_q   <= pix_d;
      nk_q    <= nk_d;
      np_q    <= np_d;
      wcnt_q  <= wcnt_d;
      wout_q  <= wout_d;
      wkern_q <= wkern_d;
      wpix_q  <= wpix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kern_d  = kern_q;
    pix_d   = pix_q;
    nk_d    = nk_q;
    np_d    = np_q;
    wcnt_d  = wcnt_q;
    wout_d  = wout_q;
    wkern_d = wkern_q;
    wpix_d  = wpix_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          nk_d    = numKern;
          np_d    = numPix;
          kern_d  = '0;
          pix_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The SRAM data is only trusted on the last WAIT edge; earlier cycles are ignored.
        if (wcnt_q == WAIT_LAST) begin
          wout_d  = weightIn;
          wkern_d = kern_q;
          wpix_d  = pix_q;
          state_d = S_PRESENT;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_PRESENT: begin
        if (weightReady) begin
          if (pix_q == np_q && kern_q == nk_q) begin
            state_d = S_DONE;
          end else if (pix_q == np_q) begin
            pix_d   = '0;
            kern_d  = kern_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      kern_d  = '0;
      pix_d   = '0;
    end
  end

  assign enableWSRAM   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PRESENT);
  assign writeWSRAM    = 1'b0;
  assign readWSRAM     = (state_q == S_ISSUE);
  assign WkernAddr     = kern_q;
  assign WpixAddr      = pix_q;
  assign weightOut     = wout_q;
  assign weightKern    = wkern_q;
  assign weightPix     = wpix_q;
  assign weightValid   = (state_q == S_PRESENT);
  assign busy          = (state_q != S_IDLE);
  assign weightsPulled = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: two instances (read latency 1 and 3) driven one at a
// time against an address-sequence / cycle-count model and a latency-accurate SRAM model.
module tb_weight_fetch_sequencer;

  localparam int KAW = 4;
  localparam int PAW = 6;

  logic           clock = 1'b0;
  logic           reset;
  logic           st     [2];
  logic           ab     [2];
  logic [KAW-1:0] nk     [2];
  logic [PAW-1:0] np     [2];
  logic [7:0]     win    [2];
  logic           en     [2];
  logic           wr     [2];
  logic           rd     [2];
  logic [KAW-1:0] wka    [2];
  logic [PAW-1:0] wpa    [2];
  logic [7:0]     wout   [2];
  logic [KAW-1:0] wkt    [2];
  logic [PAW-1:0] wpt    [2];
  logic           vld    [2];
  logic           rdy    [2];
  logic           busy   [2];
  logic           pulled [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit pend [2];
  int cnt  [2];
  int pk   [2];
  int pp   [2];
  int salt [2];

  always #5 clock = ~clock;

  weight_fetch_sequencer #(.READ_LAT(1), .KERN_AW(KAW), .PIX_AW(PAW)) u_dut_l1 (
    .clock(clock), .reset(reset), .start(st[0]), .abort(ab[0]),
    .numKern(nk[0]), .numPix(np[0]), .weightIn(win[0]),
    .enableWSRAM(en[0]), .writeWSRAM(wr[0]), .readWSRAM(rd[0]),
    .WkernAddr(wka[0]), .WpixAddr(wpa[0]), .weightOut(wout[0]),
    .weightKern(wkt[0]), .weightPix(wpt[0]), .weightValid(vld[0]),
    .weightReady(rdy[0]), .busy(busy[0]), .weightsPulled(pulled[0])
  );

  weight_fetch_sequencer #(.READ_LAT(3), .KERN_AW(KAW), .PIX_AW(PAW)) u_dut_l3 (
    .clock(clock), .reset(reset), .start(st[1]), .abort(ab[1]),
    .numKern(nk[1]), .numPix(np[1]), .weightIn(win[1]),
    .enableWSRAM(en[1]), .writeWSRAM(wr[1]), .readWSRAM(rd[1]),
    .WkernAddr(wka[1]), .WpixAddr(wpa[1]), .weightOut(wout[1]),
    .weightKern(wkt[1]), .weightPix(wpt[1]), .weightValid(vld[1]),
    .weightReady(rdy[1]), .busy(busy[1]), .weightsPulled(pulled[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] mem(input int d, input int k, input int p);
    return 8'(salt[d] + k * 16 + p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: remember reads issued this cycle, advance, then drive the SRAM output.
  task automatic tick();
    logic r [2];
    int   ak [2];
    int   ap [2];
    for (int i = 0; i < 2; i++) begin
      r[i]  = rd[i];
      ak[i] = int'(wka[i]);
      ap[i] = int'(wpa[i]);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        if (cnt[i] == 0) pend[i] = 1'b0;
        else cnt[i]--;
      end
      if (r[i]) begin
        pend[i] = 1'b1;
        cnt[i]  = lat_of(i) - 1;
        pk[i]   = ak[i];
        pp[i]   = ap[i];
      end
      win[i] = (pend[i] && cnt[i] == 0) ? mem(i, pk[i], pp[i]) : 8'($urandom);
    end
    cyc++;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    chk({tag, "_busy"},  busy[d], 0);
    chk({tag, "_valid"}, vld[d], 0);
    chk({tag, "_read"},  rd[d], 0);
    chk({tag, "_en"},    en[d], 0);
    chk({tag, "_pulse"}, pulled[d], 0);
  endtask

  // mode: 0 = ready high, 1 = first weight stalled 5 cycles, 2 = random ready.
  // abort_rd: index of the read whose WAIT cycle gets an abort (-1 = none).
  task automatic run_fetch(input int d, input int k, input int p, input int salt_v,
                           input int mode, input int abort_rd);
    int n = (k + 1) * (p + 1);
    int lat = lat_of(d);
    int reads = 0, acc = 0, stalls = 0, stall_left;
    bit done = 1'b0, abort_now = 1'b0, abort_next = 1'b0, stalled_prev = 1'b0;
    stall_left = (mode == 1) ? 5 : 0;
    salt[d] = salt_v;
    nk[d] = KAW'(k);
    np[d] = PAW'(p);
    rdy[d] = 1'b1;
    st[d] = 1'b1;
    cyc = 0;
    tick();
    st[d] = 1'b0;
    while (!done) begin
      if (cyc > n * (2 + lat) + 1 + stalls + 20) begin
        n_assert++;
        n_fail++;
        $error("FAIL timeout: no weightsPulled by cycle %0d, expected at %0d", cyc,
               n * (2 + lat) + 1 + stalls);
        break;
      end
      if (mode == 1 && acc == 0 && vld[d] && stall_left > 0) begin
        rdy[d] = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        rdy[d] = ($urandom_range(0, 2) != 0);
      end else begin
        rdy[d] = 1'b1;
      end
      if (mode != 0 && !abort_now) begin
        nk[d] = KAW'($urandom);
        np[d] = PAW'($urandom);
        st[d] = 1'($urandom);
      end
      chk("write_strobe", wr[d], 0);
      chk("busy_active", busy[d], 1);
      if (stalled_prev) chk("stall_valid_held", vld[d], 1);
      if (rd[d]) begin
        chk("rd_outstanding", 32'(reads - acc), 0);
        chk("rd_kern", wka[d], 32'(reads / (p + 1)));
        chk("rd_pix", wpa[d], 32'(reads % (p + 1)));
        chk("rd_enable", en[d], 1);
        if (reads == abort_rd) abort_next = 1'b1;
        reads++;
      end
      if (vld[d]) begin
        chk("vld_enable", en[d], 1);
        chk("vld_data", wout[d], mem(d, acc / (p + 1), acc % (p + 1)));
        chk("vld_kern_tag", wkt[d], 32'(acc / (p + 1)));
        chk("vld_pix_tag", wpt[d], 32'(acc % (p + 1)));
        if (rdy[d]) acc++;
        else stalls++;
      end
      stalled_prev = vld[d] && !rdy[d];
      if (pulled[d]) begin
        chk("done_cycle", 32'(cyc), 32'(n * (2 + lat) + 1 + stalls));
        chk("done_accepts", 32'(acc), 32'(n));
        chk("done_reads", 32'(reads), 32'(n));
        chk("done_no_valid", vld[d], 0);
        chk("done_enable", en[d], 0);
        done = 1'b1;
      end
      if (abort_now) ab[d] = 1'b1;
      tick();
      ab[d] = 1'b0;
      st[d] = 1'b0;
      if (abort_now) begin
        check_idle_outputs(d, "post_abort");
        for (int i = 0; i < 8; i++) begin
          tick();
          chk("abort_no_pulse", pulled[d], 0);
          chk("abort_stay_idle", busy[d], 0);
        end
        done = 1'b1;
      end else begin
        abort_now = abort_next;
        abort_next = 1'b0;
      end
    end
    rdy[d] = 1'b1;
    check_idle_outputs(d, "after_fetch");
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; nk[i] = '0; np[i] = '0;
      win[i] = '0; rdy[i] = 1'b1; pend[i] = 1'b0; cnt[i] = 0; salt[i] = 0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_idle_outputs(d, "reset");
      chk("reset_write", wr[d], 0);
      chk("reset_kaddr", wka[d], 0);
      chk("reset_paddr", wpa[d], 0);
      chk("reset_wout", wout[d], 0);
      chk("reset_ktag", wkt[d], 0);
      chk("reset_ptag", wpt[d], 0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();

    run_fetch(0, 0, 0, 8'h5A, 0, -1);   // minimal
    run_fetch(0, 2, 3, 0, 0, -1);       // full sweep, data = {kern,pix}
    run_fetch(0, 0, 1, 8'h33, 1, -1);   // back-pressure on first weight
    run_fetch(1, 0, 0, 8'h5A, 0, -1);   // latency 3, minimal
    run_fetch(1, 1, 2, 8'h10, 1, -1);   // latency 3, back-pressure
    run_fetch(0, 2, 3, 8'h77, 0, 6);    // abort during WAIT of (1,2)
    run_fetch(0, 0, 0, 8'hC3, 0, -1);   // restart after abort
    run_fetch(1, 2, 3, 8'h01, 2, 6);
    run_fetch(1, 0, 0, 8'h9E, 0, -1);
    run_fetch(0, 0, 63, 8'h05, 0, -1);  // longest kernel
    run_fetch(1, 15, 0, 8'h40, 0, -1);  // most kernels
    for (int i = 0; i < 6; i++) begin
      run_fetch(i % 2, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)), 2, -1);
    end

    // abort in IDLE, alone and together with start
    ab[0] = 1'b1; st[0] = 1'b1; nk[0] = 4'd1; np[0] = 6'd1;
    tick();
    check_idle_outputs(0, "abort_start_idle");
    st[0] = 1'b0;
    tick();
    check_idle_outputs(0, "abort_idle");
    ab[0] = 1'b0;
    tick();

    // asynchronous reset while a weight is presented and stalled
    nk[1] = 4'd1; np[1] = 6'd1; salt[1] = 8'hE7; rdy[1] = 1'b0; st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    for (int i = 0; i < 20 && !vld[1]; i++) tick();
    chk("pre_reset_valid", vld[1], 1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs(1, "async_reset");
    chk("async_reset_kaddr", wka[1], 0);
    chk("async_reset_paddr", wpa[1], 0);
    chk("async_reset_wout", wout[1], 0);
    chk("async_reset_ktag", wkt[1], 0);
    @(negedge clock);
    reset = 1'b1;
    rdy[1] = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick();
    check_idle_outputs(1, "after_reset");
    run_fetch(1, 1, 1, 8'h2C, 0, -1);
    run_fetch(0, 1, 2, 8'h81, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fetch_sequencer.md
Name: weight_fetch_sequencer

Overview:
Sequences the transfer of all kernel weights from the weight SRAM into the co-processor's kernel weight buffer before each layer. On `start` it walks every (kernel, pixel) weight address and issues a single read per weight. It waits the fixed SRAM read latency, then presents each captured byte to the buffer with a valid/ready handshake. When the last weight is accepted it pulses `weightsPulled`, which is the completion input of the co-processor's top-level state machine.

Parameters:
READ_LAT, 1, SRAM read latency in cycles; legal range 1..3.
KERN_AW, 4, kernel address width (maximum 16 kernels).
PIX_AW, 6, pixel-within-kernel address width (maximum 64 weights per kernel).

Ports:
clock  input  1  system clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a fetch; honoured only in IDLE.
abort  input  1  synchronous abort; returns the block to IDLE.
numKern  input  KERN_AW  number of kernels minus 1; latched on accepted `start`.
numPix  input  PIX_AW  number of weights per kernel minus 1; latched on accepted `start`.
weightIn  input  8  SRAM read data.
enableWSRAM  output  1  SRAM chip enable.
writeWSRAM  output  1  SRAM write strobe; this block only reads, so it is constant 0.
readWSRAM  output  1  one-cycle SRAM read strobe.
WkernAddr  output  KERN_AW  kernel index of the current read.
WpixAddr  output  PIX_AW  pixel index of the current read.
weightOut  output  8  registered weight presented to the kernel buffer.
weightKern  output  KERN_AW  kernel tag of `weightOut`.
weightPix  output  PIX_AW  pixel tag of `weightOut`.
weightValid  output  1  `weightOut` and its tags are valid.
weightReady  input  1  kernel buffer accepts the weight this cycle.
busy  output  1  high in every state except IDLE.
weightsPulled  output  1  one-cycle completion pulse.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=IDLE; kernel and pixel counters = 0.
  - Outputs: all strobes, `weightValid`, `busy`, `weightsPulled` = 0; `weightOut`, tags and addresses = 0.
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - On `start`=1: latch `numKern`/`numPix`, clear counters, go to ISSUE.
  - `start` in any other state is ignored.
- ISSUE (1 cycle):
  - `readWSRAM`=1; `WkernAddr`/`WpixAddr` = counters; go to WAIT.
- WAIT (exactly READ_LAT cycles):
  - Addresses are held stable.
  - `weightIn` is sampled at the rising edge ending the last WAIT cycle, i.e. the edge READ_LAT cycles after the ISSUE cycle.
  - On that edge, `weightOut` <= `weightIn`, tags <= counters, then go to PRESENT.
- PRESENT:
  - `weightValid`=1; output data and tags are held stable while `weightReady`=0 (unbounded stall allowed).
  - On `weightValid`&`weightReady`:
    - If pix==numPix and kern==numKern: go to DONE.
    - Else if pix==numPix: pix <= 0, kern <= kern+1, go to ISSUE.
    - Else: pix <= pix+1, go to ISSUE.
- DONE (1 cycle): `weightsPulled`=1, then go to IDLE.
- `enableWSRAM` = 1 in ISSUE, WAIT and PRESENT; 0 otherwise.
- `busy` = (state != IDLE).
- Throughput with `weightReady` held high: 2+READ_LAT cycles per weight.
  - Total from `start` to `weightsPulled`: (numKern+1)*(numPix+1)*(2+READ_LAT)+1 cycles, counting the accept edge.
- Counters never exceed the latched limits; wrap is by explicit compare, not by overflow.
- `abort`:
  - Has priority over every other transition.
  - Next state is IDLE; `weightValid` and strobes drop the following cycle.
  - No `weightsPulled` pulse; counters cleared.
  - `abort` in IDLE has no effect.
- `abort` together with `start` in IDLE: `abort` wins, state stays IDLE.
- An asynchronous reset mid-fetch behaves exactly as power-on reset; the partial transfer is discarded.
- Latched limits are unaffected by changes to `numKern`/`numPix` during a fetch.
- `weightsPulled` and `weightValid` are never high in the same cycle.

Test Plan:
- Minimal: READ_LAT=1, numKern=0, numPix=0, `weightReady`=1, SRAM returns 0x5A → exactly one `readWSRAM` at addr (0,0); `weightOut`=0x5A with tags (0,0) valid 1 cycle; `weightsPulled` 4 cycles after the start edge.
- Full sweep: numKern=2, numPix=3, `weightReady`=1, SRAM data = {kern,pix} → 12 reads in order (0,0),(0,1)…(2,3); tags match data; `weightsPulled` at cycle 37.
- Back-pressure: numPix=1, `weightReady` low for 5 cycles on the first weight → `weightOut`/tags stable for 5 cycles; no new `readWSRAM` until acceptance; completion delayed by exactly 5 cycles.
- Latency: READ_LAT=3 → data is sampled only on the third edge after ISSUE; garbage on `weightIn` in the earlier WAIT cycles is not captured.
- Abort/restart: `abort` during WAIT of weight (1,2) → IDLE the next cycle, no `weightsPulled`; a new `start` with numKern=0, numPix=0 fetches (0,0) correctly.
- Reset/ignore: `start` asserted while `busy` has no effect; `reset`=0 mid-PRESENT immediately clears `weightValid`, `busy` and the addresses to 0.
